// File: rtl/io_pkg.sv
// Shared types and constants for the IO-slot peripherals.
package io_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

   localparam int unsigned UART_DEFAULT_BAUD_DIV = 434;
   localparam int unsigned UART_FRAME_BITS       = 10;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// IO-bus side of the buffered UART: push strobe, byte, and status readback.
interface uart_tx_fifo_if #(
   parameter int unsigned FIFO_DEPTH = 16
) ();

   logic                          we;
   logic [7:0]                    wdata;
   logic                          clr_ovf;
   logic                          full;
   logic                          empty;
   logic [$clog2(FIFO_DEPTH):0]   level;
   logic                          busy;
   logic                          overflow;

   modport master (
      output we, wdata, clr_ovf,
      input  full, empty, level, busy, overflow
   );

   modport slave (
      input  we, wdata, clr_ovf,
      output full, empty, level, busy, overflow
   );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO; full/empty/level are decoded from a registered count.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   // A pop in the same cycle never frees a slot for a push made while full.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == '0);
   assign level   = count;
   assign dout    = mem[rd_ptr];

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 transmitter: bus pushes bytes into a FIFO, the FSM drains it
// onto a registered TX line at BAUD_DIV clocks per bit.
module uart_tx_fifo
   import io_pkg::*;
#(
   parameter int unsigned BAUD_DIV   = UART_DEFAULT_BAUD_DIV,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic           clk,
   input  logic           reset,
   uart_tx_fifo_if.slave  bus,
   output logic           tx
);

   localparam int unsigned DATA_BITS = UART_FRAME_BITS - 2;
   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
   localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

   uart_state_t                 state;
   uart_state_t                 state_nx;
   logic [15:0]                 baud_cnt;
   logic [15:0]                 baud_cnt_nx;
   logic [2:0]                  bit_idx;
   logic [2:0]                  bit_idx_nx;
   logic [7:0]                  shift;
   logic [7:0]                  shift_nx;
   logic                        tx_nx;
   logic                        pop;
   logic                        tick;
   logic                        ovf;
   logic [7:0]                  head;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_level;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.we),
      .pop   (pop),
      .din   (bus.wdata),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign tick         = (baud_cnt == BAUD_LAST);
   assign bus.full     = fifo_full;
   assign bus.empty    = fifo_empty;
   assign bus.level    = fifo_level;
   assign bus.busy     = (state != IDLE) || !fifo_empty;
   assign bus.overflow = ovf;

   // Next state, baud/bit counters, shift register and the line value to register.
   always_comb begin
      state_nx    = state;
      baud_cnt_nx = baud_cnt;
      bit_idx_nx  = bit_idx;
      shift_nx    = shift;
      pop         = 1'b0;
      tx_nx       = 1'b1;
      case (state)
         IDLE: begin
            tx_nx = 1'b1;
            if (!fifo_empty) begin
               pop         = 1'b1;
               shift_nx    = head;
               baud_cnt_nx = '0;
               state_nx    = START;
            end
         end
         START: begin
            tx_nx = 1'b0;
            if (tick) begin
               baud_cnt_nx = '0;
               bit_idx_nx  = '0;
               state_nx    = DATA;
            end else begin
               baud_cnt_nx = baud_cnt + 1'b1;
            end
         end
         DATA: begin
            tx_nx = shift[0];
            if (tick) begin
               baud_cnt_nx = '0;
               if (bit_idx == LAST_BIT) begin
                  state_nx = STOP;
               end else begin
                  shift_nx   = {1'b0, shift[7:1]};
                  bit_idx_nx = bit_idx + 1'b1;
               end
            end else begin
               baud_cnt_nx = baud_cnt + 1'b1;
            end
         end
         STOP: begin
            tx_nx = 1'b1;
            if (tick) begin
               baud_cnt_nx = '0;
               state_nx    = IDLE;
            end else begin
               baud_cnt_nx = baud_cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // FSM state, counters and the registered TX line (one cycle behind the state).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_nx;
         baud_cnt <= baud_cnt_nx;
         bit_idx  <= bit_idx_nx;
         shift    <= shift_nx;
         tx       <= tx_nx;
      end
   end

   // Sticky overflow: a dropped push sets it and wins over a same-cycle clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf <= 1'b0;
      end else if (bus.we && fifo_full) begin
         ovf <= 1'b1;
      end else if (bus.clr_ovf) begin
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a serial
// receiver per DUT decodes TX frames and compares them against the queue.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

   localparam int unsigned BD_A  = 4;
   localparam int unsigned BD_B  = 1000;
   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_a;
   logic        rst_b;
   logic        tx_a;
   logic        tx_b;
   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned cyc      = 0;
   byte unsigned q_a[$];
   byte unsigned q_b[$];
   int unsigned  starts_a[$];

   // Frame of 0xA5 on the line: start, LSB-first data, stop.
   bit          pat_a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
   byte unsigned ovf_bytes [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

   uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus_a ();
   uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus_b ();

   uart_tx_fifo #(.BAUD_DIV(BD_A), .FIFO_DEPTH(DEPTH)) dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (bus_a),
      .tx    (tx_a)
   );

   uart_tx_fifo #(.BAUD_DIV(BD_B), .FIFO_DEPTH(DEPTH)) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (bus_b),
      .tx    (tx_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   function automatic logic line_of(input int unsigned id);
      return (id == 0) ? tx_a : tx_b;
   endfunction

   function automatic logic rst_of(input int unsigned id);
      return (id == 0) ? rst_a : rst_b;
   endfunction

   // Serial receiver: samples mid-bit, abandons a frame cut by reset.
   task automatic mon(input int unsigned id, input int unsigned bd);
      logic         prev;
      logic         cur;
      logic [9:0]   bits;
      bit           ok;
      int unsigned  t0;
      byte unsigned exp_b;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         cur = line_of(id);
         if (rst_of(id) || !(prev && !cur)) begin
            prev = cur;
            continue;
         end
         t0   = cyc;
         ok   = 1'b1;
         bits = '0;
         for (int unsigned k = 0; k < io_pkg::UART_FRAME_BITS && ok; k++) begin
            for (int unsigned c = 0; c < ((k == 0) ? bd / 2 : bd) && ok; c++) begin
               @(negedge clk);
               if (rst_of(id)) ok = 1'b0;
            end
            bits[k] = line_of(id);
         end
         prev = line_of(id);
         if (!ok) continue;
         if (id == 0) starts_a.push_back(t0);
         if (((id == 0) ? q_a.size() : q_b.size()) == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame dut=%0d actual=0x%0h required=none", id, bits[8:1]);
         end else begin
            exp_b = (id == 0) ? q_a.pop_front() : q_b.pop_front();
            chk("frame_start_bit", 32'(bits[0]), 32'd0);
            chk("frame_data", 32'(bits[8:1]), 32'(exp_b));
            chk("frame_stop_bit", 32'(bits[9]), 32'd1);
         end
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int unsigned lvl_max;
      bit          seen_low;

      bus_a.we = 1'b0; bus_a.wdata = '0; bus_a.clr_ovf = 1'b0;
      bus_b.we = 1'b0; bus_b.wdata = '0; bus_b.clr_ovf = 1'b0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      fork
         mon(0, BD_A);
         mon(1, BD_B);
      join_none

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx_a), 32'd1);
      chk("rst_full", 32'(bus_a.full), 32'd0);
      chk("rst_empty", 32'(bus_a.empty), 32'd1);
      chk("rst_level", 32'(bus_a.level), 32'd0);
      chk("rst_busy", 32'(bus_a.busy), 32'd0);
      chk("rst_overflow", 32'(bus_a.overflow), 32'd0);
      chk("rst_b_tx", 32'(tx_b), 32'd1);
      rst_a = 1'b0;
      rst_b = 1'b0;

      // Idle after reset
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("idle_tx", 32'(tx_a), 32'd1);
         chk("idle_empty", 32'(bus_a.empty), 32'd1);
         chk("idle_busy", 32'(bus_a.busy), 32'd0);
         chk("idle_level", 32'(bus_a.level), 32'd0);
      end

      // Single byte 0xA5: exact line timing and busy fall
      q_a.push_back(8'hA5);
      bus_a.we = 1'b1; bus_a.wdata = 8'hA5;
      @(negedge clk);
      bus_a.we = 1'b0;
      chk("single_busy_after_push", 32'(bus_a.busy), 32'd1);
      chk("single_level_after_push", 32'(bus_a.level), 32'd1);
      @(negedge clk);
      chk("single_pre_start", 32'(tx_a), 32'd1);
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("single_tx", 32'(tx_a), 32'(pat_a5[b]));
            chk("single_busy", 32'(bus_a.busy), (b == 9 && c == 3) ? 32'd0 : 32'd1);
         end
      end

      // Back-to-back 0x55, 0x0F
      starts_a.delete();
      q_a.push_back(8'h55);
      q_a.push_back(8'h0F);
      bus_a.we = 1'b1; bus_a.wdata = 8'h55;
      @(negedge clk);
      bus_a.wdata = 8'h0F;
      lvl_max = 32'(bus_a.level);
      @(negedge clk);
      bus_a.we = 1'b0;
      for (int i = 0; i < 200 && q_a.size() != 0; i++) begin
         if (32'(bus_a.level) > lvl_max) lvl_max = 32'(bus_a.level);
         @(negedge clk);
      end
      chk("b2b_drain", q_a.size(), 32'd0);
      chk("b2b_level_peak", lvl_max, 32'd1);
      chk("b2b_frames", starts_a.size(), 32'd2);
      if (starts_a.size() == 2) chk("b2b_period", starts_a[1] - starts_a[0], 32'd41);
      for (int i = 0; i < 50 && bus_a.busy; i++) @(negedge clk);
      chk("b2b_idle", 32'(bus_a.busy), 32'd0);

      // Reset in the middle of data bit 3
      q_a.push_back(8'h00);
      q_a.push_back(8'h11);
      bus_a.we = 1'b1; bus_a.wdata = 8'h00;
      @(negedge clk);
      bus_a.wdata = 8'h11;
      @(negedge clk);
      bus_a.we = 1'b0;
      repeat (18) @(negedge clk);
      chk("midframe_tx_data", 32'(tx_a), 32'd0);
      chk("midframe_level", 32'(bus_a.level), 32'd1);
      #1 rst_a = 1'b1;
      #1;
      chk("async_rst_tx", 32'(tx_a), 32'd1);
      chk("async_rst_level", 32'(bus_a.level), 32'd0);
      chk("async_rst_empty", 32'(bus_a.empty), 32'd1);
      chk("async_rst_busy", 32'(bus_a.busy), 32'd0);
      q_a.delete();
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
      seen_low = 1'b0;
      lvl_max  = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_a == 1'b0) seen_low = 1'b1;
         if (32'(bus_a.level) > lvl_max) lvl_max = 32'(bus_a.level);
      end
      chk("post_reset_no_frame", 32'(seen_low), 32'd0);
      chk("post_reset_level", lvl_max, 32'd0);

      // Push on the first cycle after reset release
      rst_a = 1'b1;
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
      q_a.push_back(8'h3C);
      bus_a.we = 1'b1; bus_a.wdata = 8'h3C;
      @(negedge clk);
      bus_a.we = 1'b0;
      chk("first_push_level", 32'(bus_a.level), 32'd1);
      for (int i = 0; i < 100 && q_a.size() != 0; i++) @(negedge clk);
      chk("first_push_drain", q_a.size(), 32'd0);

      // Overflow on dut_b: 0x01 popped early, 0x02..0x05 fill, 0x06 dropped
      for (int i = 0; i < 6; i++) begin
         bus_b.we = 1'b1;
         bus_b.wdata = ovf_bytes[i];
         if (i < 5) q_b.push_back(ovf_bytes[i]);
         @(negedge clk);
      end
      bus_b.we = 1'b0;
      chk("ovf_flag", 32'(bus_b.overflow), 32'd1);
      chk("ovf_full", 32'(bus_b.full), 32'd1);
      chk("ovf_level", 32'(bus_b.level), 32'd4);

      // clr_ovf alone clears
      bus_b.clr_ovf = 1'b1;
      @(negedge clk);
      bus_b.clr_ovf = 1'b0;
      chk("clr_ovf_alone", 32'(bus_b.overflow), 32'd0);
      chk("clr_ovf_level", 32'(bus_b.level), 32'd4);

      // clr_ovf with a dropped push: set wins
      bus_b.clr_ovf = 1'b1;
      bus_b.we = 1'b1; bus_b.wdata = 8'h77;
      @(negedge clk);
      bus_b.clr_ovf = 1'b0;
      bus_b.we = 1'b0;
      chk("clr_ovf_collision", 32'(bus_b.overflow), 32'd1);
      chk("collision_level", 32'(bus_b.level), 32'd4);

      for (int i = 0; i < 60000 && q_b.size() != 0; i++) @(negedge clk);
      chk("ovf_drain", q_b.size(), 32'd0);
      chk("ovf_final_empty", 32'(bus_b.empty), 32'd1);
      chk("ovf_final_level", 32'(bus_b.level), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
